// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: bundles the requester streams, the FIFO write port and
// the arbiter status outputs into one interface.
//   master : producer/FIFO side (drives req_valid/req_data/req_last/fifo_full)
//   slave  : arbiter side (drives req_ready, fifo_wr_en/fifo_wr_data,
//            grant_id, busy)
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic [ID_W-1:0]               grant_id;
  logic                          busy;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares one FIFO write port among NUM_REQ valid/ready
// requesters with round-robin arbitration and bursts capped at MAX_BURST beats.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset
//   bus    : fifo_wr_arbiter_if.slave
//            req_valid/req_data/req_last in, req_ready out (per requester)
//            fifo_full in, fifo_wr_en/fifo_wr_data out (FIFO write port)
//            grant_id, busy out (arbitration status)
// Data is never registered: the granted requester's slice is muxed straight
// onto the FIFO write port, so requesters must hold data while stalled.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic              clk,
  input  logic              reset,
  fifo_wr_arbiter_if.slave  bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_id;
  logic [CNT_W-1:0] beat_cnt;
  logic             busy;

  logic                  sel_found;
  logic [ID_W-1:0]       sel_idx;
  logic [ID_W:0]         cand;
  logic                  g_valid;
  logic                  g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  in_burst;
  logic                  xfer;
  logic                  release_grant;
  logic [ID_W-1:0]       next_ptr;

  // Round-robin search: first valid requester at or after rr_ptr, modulo
  // NUM_REQ. The wrap is done by subtraction so non-power-of-two counts work.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!sel_found && cand == (ID_W+1)'(j) && bus.req_valid[j]) begin
          sel_found = 1'b1;
          sel_idx   = ID_W'(j);
        end
      end
    end
  end

  // Mux of the granted requester's stream.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        g_valid = bus.req_valid[i];
        g_last  = bus.req_last[i];
        g_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign in_burst = (state == BURST);
  assign xfer     = in_burst && g_valid && !bus.fifo_full && !reset;

  // A full FIFO freezes the grant entirely, even if the requester drops valid.
  assign release_grant = in_burst && !bus.fifo_full &&
                         (!g_valid || g_last || beat_cnt == CNT_W'(MAX_BURST - 1));

  assign next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  // Reset gates the handshake combinationally so nothing moves in a reset cycle.
  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (in_burst && !reset && !bus.fifo_full && grant_id == ID_W'(i)) begin
        bus.req_ready[i] = 1'b1;
      end
    end
  end

  assign bus.fifo_wr_en   = xfer;
  assign bus.fifo_wr_data = g_data;
  assign bus.grant_id     = grant_id;
  assign bus.busy         = busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            grant_id <= sel_idx;
            beat_cnt <= '0;
            state    <= BURST;
            busy     <= 1'b1;
          end
        end
        BURST: begin
          if (release_grant) begin
            state    <= IDLE;
            busy     <= 1'b0;
            beat_cnt <= '0;
            rr_ptr   <= next_ptr;
          end else if (xfer) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
